shift_window_buffer: RTL
========================

// Module: shift_window_buffer
//
// PURPOSE
//   Parametrised multi-lane sliding-window shift register with valid/ready flow
//   control on both the input stream and the evicted-element stream. It holds
//   the last SIZE accepted samples per lane, exposes them in parallel as a
//   window, and flags when the window is fully populated. It sits between a
//   pixel/feature streaming source and window-based compute stages
//   (e.g. filters, descriptor extraction). The eviction port can feed a chained
//   buffer or a line delay.
//
// PARAMETERS
//   DATA_WIDTH  8  bits per sample per lane
//   SIZE        8  window depth in samples (SIZE >= 2)
//   LANES       1  independent parallel lanes that shift together (LANES >= 1)
//
// PORTS
//   clk         in   1                         clock, rising edge
//   rst_n       in   1                         asynchronous active-low reset
//   clear       in   1                         synchronous flush of window/state
//   in_valid    in   1                         input sample valid
//   in_ready    out  1                         buffer can accept a sample
//   in_data     in   [LANES][DATA_WIDTH]       input sample, all lanes
//   win_data    out  [SIZE][LANES][DATA_WIDTH] window; [0] = newest
//   win_valid   out  1                         window holds SIZE valid samples
//   fill_count  out  $clog2(SIZE+1)            valid samples in window, 0..SIZE
//   out_valid   out  1                         evicted sample valid
//   out_ready   in   1                         downstream accepts evicted sample
//   out_data    out  [LANES][DATA_WIDTH]       oldest sample evicted by a shift
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): win_data=0, out_data=0, fill_count=0,
//     win_valid=0, out_valid=0. in_ready follows the combinational rule below,
//     so it is 1 during reset.
//   - accept = in_valid & in_ready & ~clear. All lanes shift together; no per-lane enable.
//   - On accept: win_data[0] <= in_data; win_data[i] <= win_data[i-1] for i = 1..SIZE-1.
//   - Eviction, full case: if fill_count==SIZE at accept, out_data <= win_data[SIZE-1]
//     and out_valid <= 1.
//   - Eviction, partial case: if fill_count<SIZE at accept, nothing is evicted and
//     fill_count <= fill_count+1. fill_count saturates at SIZE.
//   - win_valid == (fill_count==SIZE). It is registered alongside fill_count, so it
//     rises the cycle after the SIZE-th accept.
//   - Output pop: when out_valid & out_ready and there is no eviction in the same
//     cycle, out_valid <= 0 and out_data holds its value.
//   - Simultaneous pop + eviction: out_valid stays 1 and out_data takes the new
//     evicted sample. No loss and no duplicate.
//   - in_ready = ~clear & ((fill_count<SIZE) | ~out_valid | out_ready)
//     (combinational). Backpressure applies only when the window is full and an
//     eviction is pending unaccepted.
//   - Latency: in_data appears on win_data[0] one cycle after accept. A sample
//     reaches out_data on the (SIZE+1)-th accept counted from and including its own.
//   - clear=1 (sync, highest priority after reset):
//       win_data=0, fill_count=0, win_valid=0, out_valid=0;
//       out_data is held; the input beat presented that cycle is not accepted.
//   - Async reset mid-stream drops all state immediately. No partial shift is
//     observable after release.
//   - No state machine. State = window registers, fill counter, and output holding register.
//
// TESTING (SIZE=8, DATA_WIDTH=8, LANES=1 unless stated)
//   1. Fill: accept 1..8 back-to-back, out_ready=1.
//      -> fill_count 1..8; win_valid=1 the cycle after the 8th accept;
//         win_data[0]=8, win_data[7]=1; out_valid stays 0.
//   2. Evict: continue with 9, 10.
//      -> out_data=1, then 2, out_valid=1 each cycle; win_data[0]=10, win_data[7]=3.
//   3. Backpressure: window full, out_valid=1, out_ready=0, in_valid=1 for 5 cycles.
//      -> in_ready=0, window and out_data unchanged.
//      Then out_ready=1 -> same-cycle accept + eviction, out_valid stays 1.
//   4. Clear mid-fill: accept 1..5, assert clear with in_valid=1 (data 6).
//      -> fill_count=0, win_valid=0, win_data all 0, sample 6 not accepted.
//      Refill then behaves as test 1.
//   5. Async reset mid-stream: drop rst_n between clock edges while full.
//      -> all outputs at reset values before the next edge; resumes cleanly after release.
//   6. LANES=2: lane0 inputs 1..9, lane1 inputs 0x81..0x89.
//      -> both lanes windowed in lockstep; out_data = {lane0 1, lane1 0x81} on the 9th accept.

Source files
------------

// File: rtl/shift_window_buffer.sv
// rtl/shift_window_buffer.sv - multi-lane sliding-window shift register with evicted-sample output
module shift_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 8,
  parameter int LANES      = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]         in_data,
  output logic [SIZE-1:0][LANES-1:0][DATA_WIDTH-1:0] win_data,
  output logic                                     win_valid,
  output logic [$clog2(SIZE+1)-1:0]                fill_count,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0]         out_data
);

  localparam int CW = $clog2(SIZE+1);

  logic full;
  logic accept;
  logic evict;

  assign full     = (fill_count == CW'(SIZE));
  // Stall only when a full window would evict into an occupied, unaccepted output slot.
  assign in_ready = ~clear & (~full | ~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign evict    = accept & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_data   <= '0;
      out_data   <= '0;
      fill_count <= '0;
      win_valid  <= 1'b0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      win_data   <= '0;
      fill_count <= '0;
      win_valid  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        win_data <= {win_data[SIZE-2:0], in_data};
      end
      // A pop coinciding with an eviction is replaced by the new sample, so nothing is lost.
      if (evict) begin
        out_data  <= win_data[SIZE-1];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && !full) begin
        fill_count <= fill_count + CW'(1);
        win_valid  <= (fill_count == CW'(SIZE-1));
      end
    end
  end

endmodule
